// File: rtl/arch_rfl.sv
// Architectural (retirement) free register list: pops committed new PRs from the head,
// pushes the displaced PRs at the tail, and provides a recovery snapshot on flush.
module arch_rfl #(
  parameter int NUM_PR   = 80,
  parameter int NUM_AR   = 32,
  parameter int FL_DEPTH = NUM_PR - NUM_AR,
  parameter int PR_W     = 7,
  parameter int NUM_RET  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_RET-1:0]           retire_vld_i,
  input  logic [NUM_RET-1:0]           retire_rd_vld_i,
  input  logic [NUM_RET*PR_W-1:0]      retire_new_pr_i,
  input  logic [NUM_RET*PR_W-1:0]      retire_old_pr_i,
  input  logic                         flush_i,
  output logic [NUM_RET*PR_W-1:0]      rls_rd_o,
  output logic [NUM_RET-1:0]           rls_rd_vld_o,
  output logic                         arch_fl_rec_o,
  output logic [FL_DEPTH*PR_W-1:0]     arch_fl_rec_data_o,
  output logic [$clog2(FL_DEPTH+1)-1:0] free_cnt_o,
  output logic                         fl_err_o
);

  localparam int PTR_W = $clog2(FL_DEPTH);
  localparam int CNT_W = $clog2(FL_DEPTH+1);

  logic [PR_W-1:0]          mem     [FL_DEPTH];
  logic [PR_W-1:0]          mem_nxt [FL_DEPTH];
  logic [PTR_W-1:0]         head_ptr, tail_ptr, head_nxt, tail_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [PTR_W-1:0]         rank;
  logic [NUM_RET-1:0]       act;
  logic                     err_det;
  logic [NUM_RET*PR_W-1:0]  rls_nxt;
  logic [FL_DEPTH*PR_W-1:0] snap_nxt;

  // Modulo-FL_DEPTH add; both operands are below FL_DEPTH so one subtract suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W-1:0] off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= (PTR_W+1)'(FL_DEPTH)) s = s - (PTR_W+1)'(FL_DEPTH);
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    mem_nxt = mem;
    rank    = '0;
    act     = '0;
    err_det = 1'b0;
    rls_nxt = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      if (retire_vld_i[k] && retire_rd_vld_i[k]) begin
        act[k] = 1'b1;
        if (retire_new_pr_i[k*PR_W +: PR_W] != mem[wrap_add(head_ptr, rank)])
          err_det = 1'b1;
        mem_nxt[wrap_add(tail_ptr, rank)] = retire_old_pr_i[k*PR_W +: PR_W];
        rls_nxt[k*PR_W +: PR_W] = retire_old_pr_i[k*PR_W +: PR_W];
        rank = rank + 1'b1;
      end
    end
    head_nxt = wrap_add(head_ptr, rank);
    tail_nxt = wrap_add(tail_ptr, rank);
    cnt_nxt  = cnt + CNT_W'(rank) - CNT_W'(rank);
  end

  // Snapshot is taken from the post-retire list so a same-cycle retire is included.
  always_comb begin
    snap_nxt = '0;
    for (int j = 0; j < FL_DEPTH; j++)
      snap_nxt[j*PR_W +: PR_W] = mem_nxt[wrap_add(head_nxt, PTR_W'(j))];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) mem[i] <= PR_W'(NUM_AR + i);
      head_ptr           <= '0;
      tail_ptr           <= '0;
      cnt                <= CNT_W'(FL_DEPTH);
      rls_rd_o           <= '0;
      rls_rd_vld_o       <= '0;
      arch_fl_rec_o      <= 1'b0;
      arch_fl_rec_data_o <= '0;
      fl_err_o           <= 1'b0;
    end else begin
      mem           <= mem_nxt;
      head_ptr      <= head_nxt;
      tail_ptr      <= tail_nxt;
      cnt           <= cnt_nxt;
      rls_rd_o      <= rls_nxt;
      rls_rd_vld_o  <= act;
      arch_fl_rec_o <= flush_i;
      if (flush_i) arch_fl_rec_data_o <= snap_nxt;
      if (err_det) fl_err_o <= 1'b1;
    end
  end

  assign free_cnt_o = cnt;

endmodule

// File: tb/tb_arch_rfl.sv
// Self-checking bench for arch_rfl: table vectors plus hand sequences, checked
// against a queue-based model of the committed free list through a scoreboard.
module tb_arch_rfl;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [7:0]   retire_vld_i, retire_rd_vld_i;
  logic [55:0]  retire_new_pr_i, retire_old_pr_i;
  logic         flush_i;
  logic [55:0]  rls_rd_o;
  logic [7:0]   rls_rd_vld_o;
  logic         arch_fl_rec_o;
  logic [335:0] arch_fl_rec_data_o;
  logic [5:0]   free_cnt_o;
  logic         fl_err_o;

  arch_rfl dut (
    .clock(clock), .reset_n(reset_n),
    .retire_vld_i(retire_vld_i), .retire_rd_vld_i(retire_rd_vld_i),
    .retire_new_pr_i(retire_new_pr_i), .retire_old_pr_i(retire_old_pr_i),
    .flush_i(flush_i), .rls_rd_o(rls_rd_o), .rls_rd_vld_o(rls_rd_vld_o),
    .arch_fl_rec_o(arch_fl_rec_o), .arch_fl_rec_data_o(arch_fl_rec_data_o),
    .free_cnt_o(free_cnt_o), .fl_err_o(fl_err_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  vld;
    logic [7:0]  rd_vld;
    logic [55:0] new_pr;
    logic [55:0] old_pr;
    logic        flush;
    logic [7:0]  exp_vld;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [7:0]   vld;
    logic [55:0]  rd;
    logic         rec;
    logic [335:0] snap;
    logic         err;
    logic [5:0]   cnt;
  } exp_t;

  exp_t         exp_q[$];
  int           model_q[$];
  logic         model_err;
  logic [335:0] last_snap;
  int           checks = 0;
  int           failures = 0;
  vec_t         vecs[6];

  function automatic logic [55:0] slot(input int k, input int v);
    logic [55:0] r;
    r = '0;
    r[k*7 +: 7] = 7'(v);
    return r;
  endfunction

  task automatic cmp(input string name, input logic [335:0] act, input logic [335:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    for (int i = 0; i < 48; i++) model_q.push_back(32 + i);
    model_err = 1'b0;
    last_snap = '0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      cmp("scoreboard_empty", 336'(0), 336'(1));
      return;
    end
    e = exp_q.pop_front();
    cmp("rls_rd_vld", 336'(rls_rd_vld_o), 336'(e.vld));
    cmp("rls_rd", 336'(rls_rd_o), 336'(e.rd));
    cmp("rec_strobe", 336'(arch_fl_rec_o), 336'(e.rec));
    cmp("rec_data", arch_fl_rec_data_o, e.snap);
    cmp("fl_err", 336'(fl_err_o), 336'(e.err));
    cmp("free_cnt", 336'(free_cnt_o), 336'(e.cnt));
  endtask

  // Drives one cycle, updates the model and queues the expected registered outputs.
  task automatic applyStimulus(input logic [7:0] vld, input logic [7:0] rd_vld,
                               input logic [55:0] np, input logic [55:0] op, input logic fl);
    exp_t e;
    retire_vld_i    = vld;
    retire_rd_vld_i = rd_vld;
    retire_new_pr_i = np;
    retire_old_pr_i = op;
    flush_i         = fl;
    e.vld = '0;
    e.rd  = '0;
    for (int k = 0; k < 8; k++) begin
      if (vld[k] && rd_vld[k]) begin
        e.vld[k] = 1'b1;
        e.rd[k*7 +: 7] = op[k*7 +: 7];
        if (np[k*7 +: 7] != 7'(model_q[0])) model_err = 1'b1;
        void'(model_q.pop_front());
        model_q.push_back(int'(op[k*7 +: 7]));
      end
    end
    if (fl) for (int j = 0; j < 48; j++) last_snap[j*7 +: 7] = 7'(model_q[j]);
    e.rec  = fl;
    e.snap = last_snap;
    e.err  = model_err;
    e.cnt  = 6'(model_q.size());
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus('0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    cmp("rst_free_cnt", 336'(free_cnt_o), 336'(48));
    cmp("rst_rls_vld", 336'(rls_rd_vld_o), 336'(0));
    cmp("rst_fl_err", 336'(fl_err_o), 336'(0));
    cmp("rst_rec", 336'(arch_fl_rec_o), 336'(0));
    retire_vld_i = '0; retire_rd_vld_i = '0;
    retire_new_pr_i = '0; retire_old_pr_i = '0; flush_i = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    logic [55:0] np, op;
    retire_vld_i = '0; retire_rd_vld_i = '0;
    retire_new_pr_i = '0; retire_old_pr_i = '0; flush_i = 1'b0;
    reset_n = 1'b1;
    #2;
    do_reset();

    vecs[0] = '{8'h00, 8'h00, 56'h0, 56'h0, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{8'h08, 8'h08, slot(3, 32), slot(3, 5), 1'b0, 8'h08, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 56'h0, 56'h0, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'h46, 8'h52, slot(1, 33) | slot(2, 99) | slot(6, 34),
                slot(1, 7) | slot(2, 55) | slot(6, 9), 1'b0, 8'h42, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 56'h0, 56'h0, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'h03, 8'h03, slot(0, 35) | slot(1, 36),
                slot(0, 10) | slot(1, 11), 1'b1, 8'h03, 1'b0};

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].vld, vecs[v].rd_vld, vecs[v].new_pr, vecs[v].old_pr, vecs[v].flush);
      cmp($sformatf("tbl%0d_vld", v), 336'(rls_rd_vld_o), 336'(vecs[v].exp_vld));
      cmp($sformatf("tbl%0d_err", v), 336'(fl_err_o), 336'(vecs[v].exp_err));
    end
    cmp("flush_ret_entry0", 336'(arch_fl_rec_data_o[6:0]), 336'(37));
    cmp("flush_ret_tail", 336'(arch_fl_rec_data_o[335:322]), 336'({7'd11, 7'd10}));

    // Mismatch: wrong new PR, error must stick through later legal retires.
    applyStimulus(8'h01, 8'h01, slot(0, model_q[0] ^ 1), slot(0, 3), 1'b0);
    cmp("mismatch_err", 336'(fl_err_o), 336'(1));
    for (int c = 0; c < 2; c++)
      applyStimulus(8'h01, 8'h01, slot(0, model_q[0]), slot(0, 4 + c), 1'b0);
    cmp("mismatch_sticky", 336'(fl_err_o), 336'(1));

    // Mid-stream reset, then full-list snapshot.
    retire_vld_i = 8'hFF; retire_rd_vld_i = 8'hFF; flush_i = 1'b1;
    #2;
    do_reset();
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int j = 0; j < 48; j += 47)
      cmp($sformatf("post_rst_entry%0d", j), 336'(arch_fl_rec_data_o[j*7 +: 7]), 336'(32 + j));

    // Wrap: 56 pops from reset take head and tail across the 47->0 boundary.
    for (int c = 0; c < 7; c++) begin
      np = '0; op = '0;
      for (int k = 0; k < 8; k++) begin
        np[k*7 +: 7] = 7'(model_q[k]);
        op[k*7 +: 7] = 7'($urandom_range(0, 79));
      end
      applyStimulus(8'hFF, 8'hFF, np, op, 1'b0);
    end
    applyStimulus('0, '0, '0, '0, 1'b1);
    cmp("wrap_err", 336'(fl_err_o), 336'(0));
    idle();

    cmp("scoreboard_drained", 336'(exp_q.size()), 336'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
